// File: rtl/morra_pilota_if.sv
// Player-side link to the morra referee: start pulse and moves out, manche/match results back.
interface morra_pilota_if;
    logic       inizio;
    logic [1:0] primo;
    logic [1:0] secondo;
    logic [1:0] manche;
    logic [1:0] partita;

    modport master (output inizio, primo, secondo, input manche, partita);
    modport slave  (input inizio, primo, secondo, output manche, partita);
endinterface

// File: rtl/morra_pilota.sv
// Automatic match driver: plays both LFSR-driven players against the referee and
// cross-checks every manche and the match end against its own prediction.
module morra_pilota #(
    parameter logic [7:0] SEED_DEF = 8'hA5
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           i_avvia,
    input  logic [3:0]     i_cfg,
    input  logic [7:0]     i_seed,
    morra_pilota_if.master bus,
    output logic           o_occupato,
    output logic           o_fatto,
    output logic [1:0]     o_esito,
    output logic [4:0]     o_vittorie1,
    output logic [4:0]     o_vittorie2,
    output logic [4:0]     o_giocate,
    output logic           o_errore
);

    typedef enum logic [2:0] {RIPOSO, INIZIO, ATTESA, MOSSA, PAUSA, FINE} state_t;

    state_t     r_state;
    state_t     w_stateNext;

    logic       r_inizio;
    logic [1:0] r_primo;
    logic [1:0] r_secondo;
    logic [1:0] r_pred;
    logic [7:0] r_lfsr;
    logic [4:0] r_max;
    logic [4:0] r_v1;
    logic [4:0] r_v2;
    logic [4:0] r_giocate;
    logic [1:0] r_lw1;
    logic [1:0] r_lw2;
    logic       r_attesaFine;
    logic       r_errore;
    logic [1:0] r_esito;
    logic       r_occupato;
    logic       r_fatto;

    logic       w_start;
    logic       w_aggiorna;
    logic       w_fineRef;
    logic       w_timeout;
    logic       w_mancaFine;
    logic [1:0] w_mv1;
    logic [1:0] w_mv2;
    logic [1:0] w_pred;
    logic [4:0] w_v1New;
    logic [4:0] w_v2New;
    logic [4:0] w_gNew;
    logic [4:0] w_diff;
    logic       w_fineLocale;
    logic       w_fb;

    // A player never repeats the move they just won with: rotate 01->10->11->01.
    function automatic logic [1:0] scegliMossa(input logic [1:0] raw, input logic [1:0] ultimaVinta);
        logic [1:0] m;
        m = (raw == 2'b00) ? 2'b01 : raw;
        if (ultimaVinta != 2'b00 && m == ultimaVinta) begin
            case (m)
                2'b01:   m = 2'b10;
                2'b10:   m = 2'b11;
                default: m = 2'b01;
            endcase
        end
        return m;
    endfunction

    function automatic logic [1:0] risultato(input logic [1:0] p1, input logic [1:0] p2);
        if (p1 == p2)
            return 2'b11;
        else if ((p1 == 2'b10 && p2 == 2'b01) || (p1 == 2'b01 && p2 == 2'b11) ||
                 (p1 == 2'b11 && p2 == 2'b10))
            return 2'b01;
        else
            return 2'b10;
    endfunction

    assign w_mv1  = scegliMossa(r_lfsr[1:0], r_lw1);
    assign w_mv2  = scegliMossa(r_lfsr[3:2], r_lw2);
    assign w_pred = risultato(w_mv1, w_mv2);
    assign w_fb   = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];

    always_comb begin
        w_v1New = r_v1;
        w_v2New = r_v2;
        w_gNew  = r_giocate;
        case (bus.manche)
            2'b01: begin
                w_v1New = r_v1 + 5'd1;
                w_gNew  = r_giocate + 5'd1;
            end
            2'b10: begin
                w_v2New = r_v2 + 5'd1;
                w_gNew  = r_giocate + 5'd1;
            end
            2'b11: w_gNew = r_giocate + 5'd1;
            default: ;
        endcase
        w_diff       = (w_v1New >= w_v2New) ? (w_v1New - w_v2New) : (w_v2New - w_v1New);
        w_fineLocale = ((w_gNew >= 5'd4) && (w_diff >= 5'd2)) || (w_gNew == r_max);
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            r_state <= RIPOSO;
        else
            r_state <= w_stateNext;
    end

    always_comb begin
        w_stateNext = r_state;
        w_start     = 1'b0;
        w_aggiorna  = 1'b0;
        w_fineRef   = 1'b0;
        w_timeout   = 1'b0;
        w_mancaFine = 1'b0;
        case (r_state)
            RIPOSO, FINE: begin
                if (i_avvia) begin
                    w_stateNext = INIZIO;
                    w_start     = 1'b1;
                end
            end
            INIZIO: w_stateNext = ATTESA;
            ATTESA: w_stateNext = MOSSA;
            MOSSA, PAUSA: begin
                // A referee end always wins over the manche sampled in the same cycle.
                if (bus.partita != 2'b00) begin
                    w_stateNext = FINE;
                    w_fineRef   = 1'b1;
                end else if (r_giocate == r_max + 5'd1) begin
                    w_stateNext = FINE;
                    w_timeout   = 1'b1;
                end else if (r_state == MOSSA) begin
                    w_stateNext = PAUSA;
                    w_aggiorna  = 1'b1;
                end else begin
                    w_stateNext = MOSSA;
                    w_mancaFine = r_attesaFine;
                end
            end
            default: w_stateNext = RIPOSO;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_inizio     <= 1'b0;
            r_primo      <= 2'b00;
            r_secondo    <= 2'b00;
            r_pred       <= 2'b00;
            r_lfsr       <= SEED_DEF;
            r_max        <= 5'd0;
            r_v1         <= 5'd0;
            r_v2         <= 5'd0;
            r_giocate    <= 5'd0;
            r_lw1        <= 2'b00;
            r_lw2        <= 2'b00;
            r_attesaFine <= 1'b0;
            r_errore     <= 1'b0;
            r_esito      <= 2'b00;
            r_occupato   <= 1'b0;
            r_fatto      <= 1'b0;
        end else begin
            r_fatto    <= w_fineRef | w_timeout;
            r_occupato <= (w_stateNext != RIPOSO) && (w_stateNext != FINE);
            r_inizio   <= w_start;

            if (w_start) begin
                {r_primo, r_secondo} <= i_cfg;
            end else if (w_stateNext == MOSSA) begin
                r_primo   <= w_mv1;
                r_secondo <= w_mv2;
                r_pred    <= w_pred;
            end else begin
                r_primo   <= 2'b00;
                r_secondo <= 2'b00;
            end

            if (w_start) begin
                r_lfsr       <= (i_seed == 8'd0) ? SEED_DEF : i_seed;
                r_max        <= 5'd4 + {1'b0, i_cfg};
                r_v1         <= 5'd0;
                r_v2         <= 5'd0;
                r_giocate    <= 5'd0;
                r_lw1        <= 2'b00;
                r_lw2        <= 2'b00;
                r_attesaFine <= 1'b0;
                r_errore     <= 1'b0;
                r_esito      <= 2'b00;
            end

            if (r_state == PAUSA)
                r_attesaFine <= 1'b0;

            if (w_aggiorna) begin
                if (bus.manche != r_pred)
                    r_errore <= 1'b1;
                r_v1         <= w_v1New;
                r_v2         <= w_v2New;
                r_giocate    <= w_gNew;
                r_attesaFine <= w_fineLocale;
                r_lfsr       <= {r_lfsr[6:0], w_fb};
                case (bus.manche)
                    2'b01: begin
                        r_lw1 <= r_primo;
                        r_lw2 <= 2'b00;
                    end
                    2'b10: begin
                        r_lw1 <= 2'b00;
                        r_lw2 <= r_secondo;
                    end
                    2'b11: begin
                        r_lw1 <= 2'b00;
                        r_lw2 <= 2'b00;
                    end
                    default: ;
                endcase
            end

            if (w_mancaFine)
                r_errore <= 1'b1;

            if (w_fineRef)
                r_esito <= bus.partita;

            if (w_timeout) begin
                r_esito  <= 2'b11;
                r_errore <= 1'b1;
            end
        end
    end

    assign bus.inizio  = r_inizio;
    assign bus.primo   = r_primo;
    assign bus.secondo = r_secondo;
    assign o_occupato  = r_occupato;
    assign o_fatto     = r_fatto;
    assign o_esito     = r_esito;
    assign o_vittorie1 = r_v1;
    assign o_vittorie2 = r_v2;
    assign o_giocate   = r_giocate;
    assign o_errore    = r_errore;

endmodule
